// File: rtl/regfile_arbiter_if.sv
// Two-requester request/response bundle plus the software clear request
// exchanged between the requesters (master) and the register-file arbiter (slave).
interface regfile_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
);
  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              clr_req;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output clr_req,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  clr_req,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin front end sharing one write port and one registered read port of a 4-entry file.
// Reads return 2 edges after accept; readies drop while busy or while a clear is requested.
module regfile_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 2,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  regfile_arbiter_if.slave  bus,
  output logic              busy,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_rd_add,
  output logic              rf_clr,
  output logic              rf_rst_b,
  input  logic [DATA_W-1:0] rf_rd_data
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_CLR   = 2'd3;
  localparam logic [1:0] S_RESET = CLR_ON_RESET ? S_INIT : S_RUN;

  logic [1:0]        state_q, state_d;
  logic              clr_pend_q, clr_pend_d;
  logic              ptr_q, ptr_d;
  logic              tag_vld_q, tag_id_q;
  logic              rsp0_vld_q, rsp1_vld_q;
  logic              wr_en_q, clr_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_add_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              gnt_en, both_vld, gnt0, gnt1, gnt_any, gnt_we, drained;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;

  assign gnt_en    = !rst && (state_q == S_RUN) && !bus.clr_req && !clr_pend_q;
  assign both_vld  = bus.req0_valid && bus.req1_valid;
  assign gnt0      = gnt_en && bus.req0_valid && (!bus.req1_valid || !ptr_q);
  assign gnt1      = gnt_en && bus.req1_valid && (!bus.req0_valid ||  ptr_q);
  assign gnt_any   = gnt0 || gnt1;
  assign gnt_we    = gnt1 ? bus.req1_we    : bus.req0_we;
  assign gnt_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
  assign gnt_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
  assign drained   = !tag_vld_q && !rsp0_vld_q && !rsp1_vld_q;

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp0_valid = rsp0_vld_q;
  assign bus.rsp1_valid = rsp1_vld_q;
  assign bus.rsp0_rdata = rf_rd_data;
  assign bus.rsp1_rdata = rf_rd_data;

  assign busy       = (state_q != S_RUN);
  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;
  assign rf_rd_add  = rd_add_q;
  assign rf_clr     = clr_q;
  assign rf_rst_b   = ~rst;

  always_comb begin
    state_d    = state_q;
    clr_pend_d = clr_pend_q;
    ptr_d      = (gnt_en && both_vld) ? ~ptr_q : ptr_q;
    case (state_q)
      S_INIT:  state_d = S_CLR;
      S_RUN:   if (bus.clr_req || clr_pend_q) state_d = S_DRAIN;
      S_DRAIN: if (drained) state_d = S_CLR;
      S_CLR:   state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
    // Requests seen while a clear is already on its way fold into that clear.
    if (state_q == S_CLR) begin
      clr_pend_d = 1'b0;
    end else if (state_q != S_RUN && bus.clr_req) begin
      clr_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      clr_pend_q <= 1'b0;
      ptr_q      <= 1'b0;
      tag_vld_q  <= 1'b0;
      tag_id_q   <= 1'b0;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_add_q   <= '0;
      clr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      ptr_q      <= ptr_d;
      tag_vld_q  <= gnt_any && !gnt_we;
      tag_id_q   <= gnt1;
      rsp0_vld_q <= tag_vld_q && !tag_id_q;
      rsp1_vld_q <= tag_vld_q &&  tag_id_q;
      wr_en_q    <= gnt_any && gnt_we;
      clr_q      <= (state_d == S_CLR);
      if (gnt_any && gnt_we) begin
        wr_addr_q <= gnt_addr;
        wr_data_q <= gnt_wdata;
      end
      if (gnt_any && !gnt_we) begin
        rd_add_q <= gnt_addr;
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench: two arbiters (clear-on-reset on and off), each driving its own register-file model,
// checked every cycle against a transaction-level model plus directed literal expectations.
module tb_regfile_arbiter;
  localparam int DW = 32;
  localparam int AW = 2;
  localparam logic [31:0] PRESET = 32'h0000AA55;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    v   [2];
  logic [1:0]    we  [2];
  logic [AW-1:0] a0  [2];
  logic [AW-1:0] a1  [2];
  logic [DW-1:0] d0  [2];
  logic [DW-1:0] d1  [2];
  logic          cr  [2];
  logic [1:0]    rdy [2];
  logic [1:0]    rv  [2];
  logic [DW-1:0] rd0 [2];
  logic [DW-1:0] rd1 [2];
  logic          busy_w [2];
  logic          wen_w  [2];
  logic          clr_w  [2];
  logic          rstb_w [2];

  regfile_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] mem [4];
    logic [DW-1:0] rdq, wd;
    logic [AW-1:0] wa, ra;
    logic          wen, clr, rstb, bsy;

    assign bus[g].req0_valid = v[g][0];
    assign bus[g].req0_we    = we[g][0];
    assign bus[g].req0_addr  = a0[g];
    assign bus[g].req0_wdata = d0[g];
    assign bus[g].req1_valid = v[g][1];
    assign bus[g].req1_we    = we[g][1];
    assign bus[g].req1_addr  = a1[g];
    assign bus[g].req1_wdata = d1[g];
    assign bus[g].clr_req    = cr[g];

    regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CLR_ON_RESET(g == 0)) u_dut (
      .clk(clk), .rst(rst), .bus(bus[g]), .busy(bsy),
      .rf_wr_en(wen), .rf_wr_addr(wa), .rf_wr_data(wd), .rf_rd_add(ra),
      .rf_clr(clr), .rf_rst_b(rstb), .rf_rd_data(rdq)
    );

    // Register file: rst_b zeroes, clr presets, registered read port.
    always @(posedge clk) begin
      if (!rstb) begin
        for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else if (clr) begin
        for (int i = 0; i < 4; i++) mem[i] <= PRESET;
      end else if (wen) begin
        mem[wa] <= wd;
      end
      rdq <= rstb ? mem[ra] : '0;
    end

    assign rdy[g]    = {bus[g].req1_ready, bus[g].req0_ready};
    assign rv[g]     = {bus[g].rsp1_valid, bus[g].rsp0_valid};
    assign rd0[g]    = bus[g].rsp0_rdata;
    assign rd1[g]    = bus[g].rsp1_rdata;
    assign busy_w[g] = bsy;
    assign wen_w[g]  = wen;
    assign clr_w[g]  = clr;
    assign rstb_w[g] = rstb;
  end

  typedef struct {
    int          g;
    int          id;
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [2][4];
  int          cyc = 0;
  int          ncmp = 0;
  int          nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    ncmp++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Model: contents change at accept time; a read carries the value current at its accept.
  always @(negedge clk) begin
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  adr;
    if (cyc > 0) begin
      for (int g = 0; g < 2; g++) begin
        for (int n = 0; n < 2; n++) begin
          ev = 1'b0;
          ed = '0;
          for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].g == g && sb[i].id == n && sb[i].due == cyc) begin
              ev = 1'b1;
              ed = sb[i].data;
              sb.delete(i);
              break;
            end
          end
          chk($sformatf("rsp_valid[%0d][%0d]", g, n), rv[g][n], ev);
          if (ev) chk($sformatf("rsp_rdata[%0d][%0d]", g, n), n ? rd1[g] : rd0[g], ed);
        end
        chk($sformatf("clr_wr_overlap[%0d]", g), clr_w[g] & wen_w[g], 0);
        chk($sformatf("rf_rst_b[%0d]", g), rstb_w[g], !rst);
        chk($sformatf("double_grant[%0d]", g), rdy[g] == 2'b11, 0);
      end
      if (rst) begin
        sb.delete();
        for (int a = 0; a < 4; a++) begin
          model[0][a] = PRESET;
          model[1][a] = '0;
        end
      end else begin
        for (int g = 0; g < 2; g++) begin
          if (cr[g]) for (int a = 0; a < 4; a++) model[g][a] = PRESET;
          for (int n = 0; n < 2; n++) begin
            if (v[g][n] && rdy[g][n]) begin
              chk($sformatf("grant_with_clr_req[%0d]", g), cr[g], 0);
              adr = n ? a1[g] : a0[g];
              if (we[g][n]) model[g][adr] = n ? d1[g] : d0[g];
              else sb.push_back('{g: g, id: n, due: cyc + 2, data: model[g][adr]});
            end
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic wait_ready(input int g, input int n, output int waited, output int clrs);
    waited = 0;
    clrs   = 0;
    @(negedge clk);
    while (!rdy[g][n] && waited < 30) begin
      clrs += int'(clr_w[g]);
      @(negedge clk);
      waited++;
    end
    chk($sformatf("ready_seen[%0d][%0d]", g, n), rdy[g][n], 1);
    @(posedge clk);
    #1;
    v[g][n] = 1'b0;
  endtask

  task automatic issue(input int g, input int n, input bit w, input logic [1:0] a,
                       input logic [31:0] d);
    int waited, clrs;
    v[g][n]  = 1'b1;
    we[g][n] = w;
    if (n == 0) begin
      a0[g] = a;
      d0[g] = d;
    end else begin
      a1[g] = a;
      d1[g] = d;
    end
    wait_ready(g, n, waited, clrs);
  endtask

  task automatic wait_rsp(input int g, input int n, input logic [31:0] expv);
    @(negedge clk);
    chk($sformatf("rsp_early[%0d][%0d]", g, n), rv[g][n], 0);
    @(negedge clk);
    chk($sformatf("rsp_on_time[%0d][%0d]", g, n), rv[g][n], 1);
    chk($sformatf("rsp_data[%0d][%0d]", g, n), n ? rd1[g] : rd0[g], expv);
    chk($sformatf("rsp_other_quiet[%0d][%0d]", g, n), rv[g][1 - n], 0);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int g, input int n, input logic [1:0] a, input logic [31:0] expv);
    issue(g, n, 1'b0, a, '0);
    wait_rsp(g, n, expv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, clrs;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      v[g] = '0; we[g] = '0; a0[g] = '0; a1[g] = '0;
      d0[g] = '0; d1[g] = '0; cr[g] = 1'b0;
    end

    // Test 1: reset values, post-reset clear sequence, preset readback.
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy_a", busy_w[0], 1);
    chk("rst_busy_b", busy_w[1], 0);
    chk("rst_ready_a", rdy[0], 0);
    chk("rst_wr_en_a", wen_w[0], 0);
    chk("rst_clr_a", clr_w[0], 0);
    chk("rst_rsp_a", rv[0], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_busy", busy_w[0], 1);
    chk("init_clr", clr_w[0], 0);
    @(negedge clk);
    chk("clr_busy", busy_w[0], 1);
    chk("clr_pulse", clr_w[0], 1);
    @(negedge clk);
    chk("run_busy", busy_w[0], 0);
    chk("run_clr", clr_w[0], 0);
    @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) rd(0, 0, a[1:0], PRESET);

    // Test 2: back-to-back write then read of the same address by the other requester.
    issue(0, 0, 1'b1, 2'd0, 32'h00112233);
    rd(0, 1, 2'd0, 32'h00112233);

    // Test 3: both requesters valid; grants alternate starting with requester 0.
    v[0] = 2'b11; we[0] = 2'b11;
    a0[0] = 2'd1; d0[0] = 32'h44556677;
    a1[0] = 2'd2; d1[0] = 32'h8899AABB;
    @(negedge clk);
    chk("t3_grant_first", rdy[0], 2'b01);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t3_grant_second", rdy[0], 2'b10);
    @(posedge clk);
    #1 v[0][1] = 1'b0;
    @(negedge clk);
    chk("t3_grant_third", rdy[0], 2'b01);
    @(posedge clk);
    #1 v[0] = 2'b00; we[0] = 2'b00;
    rd(0, 0, 2'd1, 32'h44556677);
    rd(0, 1, 2'd2, 32'h8899AABB);

    // Test 4: read in flight when a clear is requested; response still delivered.
    issue(0, 1, 1'b0, 2'd2, '0);
    cr[0] = 1'b1;
    v[0][0] = 1'b1; we[0][0] = 1'b0; a0[0] = 2'd2;
    @(negedge clk);
    chk("t4_ready_on_clr_req", rdy[0], 0);
    @(posedge clk);
    #1 cr[0] = 1'b0;
    @(negedge clk);
    chk("t4_rsp_valid", rv[0][1], 1);
    chk("t4_rsp_data", rd1[0], 32'h8899AABB);
    chk("t4_busy_drain", busy_w[0], 1);
    chk("t4_ready_drain", rdy[0], 0);
    @(posedge clk);
    #1;
    wait_ready(0, 0, waited, clrs);
    chk("t4_wait_cycles", waited, 2);
    chk("t4_clr_count", clrs, 1);
    wait_rsp(0, 0, PRESET);

    // Test 6: write coinciding with clr_req waits for the clear, then persists.
    v[0][0] = 1'b1; we[0][0] = 1'b1; a0[0] = 2'd3; d0[0] = 32'hCAFEF00D;
    cr[0] = 1'b1;
    @(negedge clk);
    chk("t6_ready_on_clr_req", rdy[0][0], 0);
    chk("t6_wr_en_on_clr_req", wen_w[0], 0);
    @(posedge clk);
    #1 cr[0] = 1'b0;
    wait_ready(0, 0, waited, clrs);
    chk("t6_wait_cycles", waited, 2);
    chk("t6_clr_count", clrs, 1);
    @(negedge clk);
    chk("t6_wr_en_after", wen_w[0], 1);
    chk("t6_clr_after", clr_w[0], 0);
    repeat (100) @(posedge clk);
    #1;
    rd(0, 0, 2'd3, 32'hCAFEF00D);
    rd(0, 1, 2'd1, PRESET);

    // Test 5: no clear-on-reset instance; reset drops an in-flight read and zeroes the file.
    issue(1, 0, 1'b1, 2'd1, 32'hDEADBEEF);
    issue(1, 1, 1'b0, 2'd1, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_ready_in_rst", rdy[1], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_dropped_rsp", rv[1], 0);
    chk("t5_busy", busy_w[1], 0);
    @(negedge clk);
    chk("t5_dropped_rsp_late", rv[1], 0);
    @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) rd(1, 0, a[1:0], 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
